// File: rtl/ks_seq_pkg.sv
// Shared definitions for the block-serial Kogge-Stone subtractor.
//   - default operand width and slice width
//   - FSM state encoding (IDLE / RUN / DONE)
//   - helpers that derive the slice count and slice-index width
package ks_seq_pkg;

    localparam int KS_WIDTH_DEF = 32;
    localparam int KS_SLICE_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_e;

    // Number of slice passes needed to cover the full operand.
    function automatic int ks_num_slices(input int width, input int slice);
        return width / slice;
    endfunction

    // Index register width; never below one bit so a single-slice build still has a counter.
    function automatic int ks_idx_width(input int ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

endpackage

// File: rtl/ks_slice.sv
// Combinational SLICE-bit Kogge-Stone adder: s = a + b + cin.
// Ports:
//   a, b  in   SLICE  addends
//   cin   in   1      carry into bit 0
//   s     out  SLICE  sum
//   cout  out  1      carry out of the top bit
module ks_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    localparam int LEVELS = (SLICE > 1) ? $clog2(SLICE) : 0;

    logic [SLICE-1:0] g [0:LEVELS];
    logic [SLICE-1:0] p [0:LEVELS];
    logic [SLICE-1:0] prop;
    logic [SLICE:0]   carry;

    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            g[l] = '0;
            p[l] = '0;
        end
        prop = a ^ b;
        g[0] = a & b;
        p[0] = prop;
        // Fold cin into bit 0 so every prefix G[i] is directly the carry out of bit i.
        g[0][0] = (a[0] & b[0]) | (prop[0] & cin);

        // Prefix tree: level l combines each bit with the group 2^l positions below it.
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < SLICE; i++) begin
                if (i >= (1 << l)) begin
                    g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                    p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
                end else begin
                    g[l+1][i] = g[l][i];
                    p[l+1][i] = p[l][i];
                end
            end
        end

        carry[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            carry[i+1] = g[LEVELS][i];
        end
        s    = prop ^ carry[SLICE-1:0];
        cout = carry[SLICE];
    end

endmodule

// File: rtl/ks_sub32_seq.sv
// Block-serial subtractor: s = x1 + ~x2 + cin, computed one SLICE-bit chunk per
// cycle through a single shared Kogge-Stone slice with a registered inter-slice carry.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (x1, x2, cin)
//   out_valid / out_ready result handshake (s, cout, ovf, zero)
//   cout  1 = no borrow; ovf = signed overflow; zero = (s == 0)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE. The
// producer side is never re-accepted in the cycle a result is consumed, and the
// result outputs do not change while out_valid is high.
module ks_sub32_seq
    import ks_seq_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH_DEF,
    parameter int SLICE = KS_SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NS = ks_num_slices(WIDTH, SLICE);
    localparam int IW = ks_idx_width(NS);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    logic [SLICE-1:0] slice_s;
    logic             slice_cout;
    logic [WIDTH-1:0] s_next;

    ks_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_reg[idx*SLICE +: SLICE]),
        .b    (b_reg[idx*SLICE +: SLICE]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // s_reg with the current slice merged in; on the last pass this is the full
    // result, which zero and ovf need in the same edge.
    always_comb begin
        s_next = s_reg;
        s_next[idx*SLICE +: SLICE] = slice_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= x1;
                        b_reg <= ~x2;
                        carry <= cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_reg <= s_next;
                    carry <= slice_cout;
                    idx   <= idx + IW'(1);
                    if (idx == IW'(NS - 1)) begin
                        cout_reg <= slice_cout;
                        ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                    (s_next[WIDTH-1] != a_reg[WIDTH-1]);
                        zero_reg <= (s_next == '0);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s         = s_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_ks_sub32_seq.sv
module tb_ks_sub32_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    int checks = 0;
    int errors = 0;

    ks_sub32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge; the accept happens on the next rising edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        x1       = a;
        x2       = b;
        cin      = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count rising edges after the accept until out_valid, bounded.
    task automatic wait_result(input string tag, input logic [W-1:0] es, input logic ec,
                               input logic eo, input logic ez);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_s"},    64'(s),    64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"},  64'(ovf),  64'(eo));
        check({tag, "_zero"}, 64'(zero), 64'(ez));
        check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_retire_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_retire_in_ready"},  64'(in_ready),  64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
        start_op(a, b, c);
        wait_result(tag, es, ec, eo, ez);
        retire(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x1        = '0;
        x2        = '0;
        cin       = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_s",         64'(s),         64'd0);
        check("reset_cout",      64'(cout),      64'd0);
        check("reset_ovf",       64'(ovf),       64'd0);
        check("reset_zero",      64'(zero),      64'd0);
        rst = 1'b0;

        run_op("sub_5_3",      32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_op("sub_0_1",      32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_min_1",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_equal",    32'h1234_ABCD, 32'h1234_ABCD, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_borrowin", 32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
        run_op("sub_max_neg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Hold DONE with out_ready low; a new operand pulse must be ignored.
        start_op(32'h0000_0009, 32'h0000_0004, 1'b1);
        wait_result("hold", 32'h0000_0005, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                x1       = 32'hDEAD_BEEF;
                x2       = 32'h0000_0001;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready",  64'(in_ready),  64'd0);
            check("hold_s",         64'(s),         64'h5);
            check("hold_cout",      64'(cout),      64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("hold_s_after_pulse", 64'(s), 64'h5);
        retire("hold");

        // Asynchronous reset in the middle of a computation.
        start_op(32'h1111_1111, 32'h0101_0101, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("abort_partial_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_s",         64'(s),         64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_cout",      64'(cout),      64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("after_abort", 32'h0000_0007, 32'h0000_0002, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
